// File: rtl/bmp_pkg.sv
// Shared types and header layout for the BMP stream parser.
// Offsets are byte indices into the 54-byte BMP file/info header.
package bmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SKIP = 3'd2,
    S_PIX  = 3'd3,
    S_PAD  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int SIG0      = 0;
  localparam int SIG1      = 1;
  localparam int OFF_LO    = 10;
  localparam int W_LO      = 18;
  localparam int H_LO      = 22;
  localparam int BPP_LO    = 28;
  localparam int HDR_LAST  = 53;
  localparam int HDR_BYTES = 54;

  localparam logic [7:0]  BMP_SIG0 = 8'h42;
  localparam logic [7:0]  BMP_SIG1 = 8'h4D;
  localparam logic [15:0] BPP_24   = 16'd24;

endpackage

// File: rtl/bmp_field_capture.sv
// Little-endian field assembler: grabs NB bytes starting at
// stream index LO into one word.
module bmp_field_capture #(
  parameter int CNT_W = 24,
  parameter int LO    = 0,
  parameter int NB    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  idx,
  input  logic [7:0]        data,
  output logic [8*NB-1:0]   field
);

  logic [CNT_W-1:0] rel;

  assign rel = idx - CNT_W'(LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field <= '0;
    end else if (en && rel < CNT_W'(NB)) begin
      for (int k = 0; k < NB; k++) begin
        if (rel == CNT_W'(k)) field[8*k +: 8] <= data;
      end
    end
  end

endmodule

// File: rtl/bmp_stream_parser.sv
// BMP header parser and 24-bit pixel assembler fed by the SPI byte stream.
// Define BMP_TOPDOWN_EN to accept negative (top-down) heights.
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int DIM_W = 12,
  parameter int CNT_W = 24
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Frame_Start,
  input  logic [7:0]       Byte_In,
  input  logic             Byte_Valid,
  output logic [23:0]      Pix_Data,
  output logic             Pix_Valid,
  output logic [DIM_W-1:0] Pix_X,
  output logic [DIM_W-1:0] Pix_Y,
  output logic             Row_End,
  output logic [DIM_W-1:0] Img_Width,
  output logic [DIM_W-1:0] Img_Height,
  output logic             Frame_Done,
  output logic             Hdr_Err,
  output logic [2:0]       State
);

  state_t state, nstate;

  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] off_q;
  logic [1:0]       pad_q;
  logic [1:0]       pad_cnt;
  logic [1:0]       phase;
  logic             topdown_q;
  logic [DIM_W-1:0] x, y;
  logic [7:0]       b_q, g_q;

  logic [31:0] off_f, w_f, h_f, h_abs;
  logic [15:0] bpp_f;
  logic        acc, hdr_en, td_hdr, h_neg_bad, hdr_bad;
  logic        x_last, row_last, pad_last;

  assign acc    = Byte_Valid & ~Frame_Start;
  assign hdr_en = acc && (state == S_HDR);
  assign State  = state;

  bmp_field_capture #(.CNT_W(CNT_W), .LO(OFF_LO), .NB(4)) u_off (
    .clk(Clk), .rst_n(Reset), .en(hdr_en), .idx(bcnt),
    .data(Byte_In), .field(off_f)
  );

  bmp_field_capture #(.CNT_W(CNT_W), .LO(W_LO), .NB(4)) u_w (
    .clk(Clk), .rst_n(Reset), .en(hdr_en), .idx(bcnt),
    .data(Byte_In), .field(w_f)
  );

  bmp_field_capture #(.CNT_W(CNT_W), .LO(H_LO), .NB(4)) u_h (
    .clk(Clk), .rst_n(Reset), .en(hdr_en), .idx(bcnt),
    .data(Byte_In), .field(h_f)
  );

  bmp_field_capture #(.CNT_W(CNT_W), .LO(BPP_LO), .NB(2)) u_bpp (
    .clk(Clk), .rst_n(Reset), .en(hdr_en), .idx(bcnt),
    .data(Byte_In), .field(bpp_f)
  );

`ifdef BMP_TOPDOWN_EN
  assign td_hdr    = h_f[31];
  assign h_abs     = h_f[31] ? (~h_f + 32'd1) : h_f;
  assign h_neg_bad = 1'b0;
`else
  assign td_hdr    = 1'b0;
  assign h_abs     = h_f;
  assign h_neg_bad = h_f[31];
`endif

  // All fields are in place well before the last header byte.
  assign hdr_bad = (bpp_f != BPP_24)
                 | (w_f == 32'd0)
                 | ((w_f >> DIM_W) != 32'd0)
                 | (h_abs == 32'd0)
                 | ((h_abs >> DIM_W) != 32'd0)
                 | (off_f < 32'(HDR_BYTES))
                 | ((64'(off_f) >> CNT_W) != 64'd0)
                 | h_neg_bad;

  assign x_last   = (x == Img_Width - DIM_W'(1));
  assign row_last = topdown_q ? (y == Img_Height - DIM_W'(1))
                              : (y == '0);
  assign pad_last = (pad_cnt == pad_q - 2'd1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (Frame_Start) begin
      nstate = S_IDLE;
    end else if (Byte_Valid) begin
      unique case (state)
        S_IDLE: nstate = (Byte_In == BMP_SIG0) ? S_HDR : S_ERR;
        S_HDR: begin
          if (bcnt == CNT_W'(SIG1) && Byte_In != BMP_SIG1)
            nstate = S_ERR;
          else if (bcnt == CNT_W'(HDR_LAST))
            nstate = hdr_bad ? S_ERR
                   : (off_f == 32'(HDR_BYTES)) ? S_PIX : S_SKIP;
        end
        S_SKIP: if (bcnt == off_q - CNT_W'(1)) nstate = S_PIX;
        S_PIX: begin
          if (phase == 2'd2 && x_last) begin
            if (pad_q != 2'd0) nstate = S_PAD;
            else if (row_last) nstate = S_DONE;
          end
        end
        S_PAD: if (pad_last) nstate = row_last ? S_DONE : S_PIX;
        default: nstate = state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bcnt       <= '0;
      off_q      <= '0;
      pad_q      <= '0;
      pad_cnt    <= '0;
      phase      <= '0;
      topdown_q  <= 1'b0;
      x          <= '0;
      y          <= '0;
      b_q        <= '0;
      g_q        <= '0;
      Pix_Data   <= '0;
      Pix_Valid  <= 1'b0;
      Pix_X      <= '0;
      Pix_Y      <= '0;
      Row_End    <= 1'b0;
      Img_Width  <= '0;
      Img_Height <= '0;
      Frame_Done <= 1'b0;
      Hdr_Err    <= 1'b0;
    end else begin
      Pix_Valid <= 1'b0;
      Row_End   <= 1'b0;
      if (Frame_Start) begin
        bcnt       <= '0;
        phase      <= '0;
        pad_cnt    <= '0;
        x          <= '0;
        y          <= '0;
        Frame_Done <= 1'b0;
        Hdr_Err    <= 1'b0;
      end else if (acc) begin
        if (state != S_DONE && state != S_ERR) bcnt <= bcnt + CNT_W'(1);
        unique case (state)
          S_IDLE: if (Byte_In != BMP_SIG0) Hdr_Err <= 1'b1;
          S_HDR: begin
            if (bcnt == CNT_W'(SIG1) && Byte_In != BMP_SIG1) begin
              Hdr_Err <= 1'b1;
            end else if (bcnt == CNT_W'(HDR_LAST)) begin
              if (hdr_bad) begin
                Hdr_Err <= 1'b1;
              end else begin
                Img_Width  <= w_f[DIM_W-1:0];
                Img_Height <= h_abs[DIM_W-1:0];
                pad_q      <= w_f[1:0];
                off_q      <= off_f[CNT_W-1:0];
                topdown_q  <= td_hdr;
                x          <= '0;
                y          <= td_hdr ? '0 : h_abs[DIM_W-1:0] - DIM_W'(1);
                phase      <= '0;
              end
            end
          end
          S_PIX: begin
            unique case (phase)
              2'd0: begin b_q <= Byte_In; phase <= 2'd1; end
              2'd1: begin g_q <= Byte_In; phase <= 2'd2; end
              default: begin
                phase     <= 2'd0;
                Pix_Data  <= {Byte_In, g_q, b_q};
                Pix_Valid <= 1'b1;
                Pix_X     <= x;
                Pix_Y     <= y;
                Row_End   <= x_last;
                if (!x_last) begin
                  x <= x + DIM_W'(1);
                end else if (pad_q != 2'd0) begin
                  pad_cnt <= '0;
                end else begin
                  x <= '0;
                  y <= topdown_q ? y + DIM_W'(1) : y - DIM_W'(1);
                  if (row_last) Frame_Done <= 1'b1;
                end
              end
            endcase
          end
          S_PAD: begin
            pad_cnt <= pad_cnt + 2'd1;
            if (pad_last) begin
              x <= '0;
              y <= topdown_q ? y + DIM_W'(1) : y - DIM_W'(1);
              if (row_last) Frame_Done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
